// File: rtl/stripes_serial_dispatcher.sv
// Stripes serial dispatcher: takes Tw x Tn bricks of N-bit neurons from the
// NBin side and streams them LSB-first, one bit per neuron per beat, for the
// brick's effective precision. An active slot streams while a pending slot
// holds the next brick so consecutive bricks run back-to-back.
module stripes_serial_dispatcher #(
  parameter int N      = 16,
  parameter int Tn     = 16,
  parameter int Tw     = 16,
  parameter int PREC_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [N*Tn*Tw-1:0]    i_neurons,
  input  logic [PREC_W-1:0]     i_precision,
  input  logic [Tw-1:0]         i_load,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [Tn*Tw-1:0]      o_serial,
  output logic                  o_first_cycle,
  output logic                  o_last_cycle,
  output logic [PREC_W-1:0]     o_precision,
  output logic [Tw-1:0]         o_load,
  output logic                  o_busy
);

  localparam int LANES = Tn * Tw;
  localparam int DW    = N * LANES;
  localparam logic [PREC_W-1:0] PMAX = PREC_W'(N);
  localparam logic [PREC_W-1:0] PONE = PREC_W'(1);
  localparam logic [PREC_W-1:0] PZERO = {PREC_W{1'b0}};

  // A request of zero or wider than a neuron means "all N bits".
  function automatic logic [PREC_W-1:0] eff_prec(input logic [PREC_W-1:0] p);
    if ((p == PZERO) || (p > PMAX)) begin
      return PMAX;
    end else begin
      return p;
    end
  endfunction

  // Shift every neuron lane right by one so the next bit lands in its LSB.
  function automatic logic [DW-1:0] shift_lanes(input logic [DW-1:0] d);
    logic [DW-1:0] r;
    r = {DW{1'b0}};
    for (int l = 0; l < LANES; l++) begin
      r[l*N +: N] = {1'b0, d[l*N+1 +: N-1]};
    end
    return r;
  endfunction

  logic                act_valid_q, act_valid_d;
  logic [DW-1:0]       act_data_q, act_data_d;
  logic [PREC_W-1:0]   act_prec_q, act_prec_d;
  logic [Tw-1:0]       act_load_q, act_load_d;
  logic [PREC_W-1:0]   cnt_q, cnt_d;
  logic                pend_valid_q, pend_valid_d;
  logic [DW-1:0]       pend_data_q, pend_data_d;
  logic [PREC_W-1:0]   pend_prec_q, pend_prec_d;
  logic [Tw-1:0]       pend_load_q, pend_load_d;
  logic                ready_q, ready_d;
  logic                first_q, first_d;
  logic                last_q, last_d;
  logic                busy_q, busy_d;
  logic                fire_s, complete_s, accept_s;
  logic [LANES-1:0]    serial_s;

  assign fire_s     = act_valid_q & i_ready;
  assign complete_s = fire_s & last_q;
  assign accept_s   = i_valid & ready_q;

  // Next-state: shift on a fire, promote pending on completion, place new bricks.
  always_comb begin
    act_valid_d  = act_valid_q;
    act_data_d   = act_data_q;
    act_prec_d   = act_prec_q;
    act_load_d   = act_load_q;
    cnt_d        = cnt_q;
    pend_valid_d = pend_valid_q;
    pend_data_d  = pend_data_q;
    pend_prec_d  = pend_prec_q;
    pend_load_d  = pend_load_q;

    if (fire_s) begin
      act_data_d = shift_lanes(act_data_q);
      cnt_d      = cnt_q + PONE;
    end else begin
      act_data_d = act_data_q;
      cnt_d      = cnt_q;
    end

    if (complete_s) begin
      if (pend_valid_q) begin
        act_data_d   = pend_data_q;
        act_prec_d   = pend_prec_q;
        act_load_d   = pend_load_q;
        cnt_d        = PZERO;
        pend_valid_d = 1'b0;
        pend_data_d  = {DW{1'b0}};
        pend_prec_d  = PZERO;
        pend_load_d  = {Tw{1'b0}};
      end else begin
        // Idle slot is fully cleared so stale high bits never reach o_serial.
        act_valid_d = 1'b0;
        act_data_d  = {DW{1'b0}};
        act_prec_d  = PZERO;
        act_load_d  = {Tw{1'b0}};
        cnt_d       = PZERO;
      end
    end else begin
      act_valid_d = act_valid_d;
    end

    // o_ready is low whenever pending is full, so an accept never collides
    // with a pending-to-active promotion.
    if (accept_s) begin
      if (!act_valid_q || complete_s) begin
        act_valid_d = 1'b1;
        act_data_d  = i_neurons;
        act_prec_d  = eff_prec(i_precision);
        act_load_d  = i_load;
        cnt_d       = PZERO;
      end else begin
        pend_valid_d = 1'b1;
        pend_data_d  = i_neurons;
        pend_prec_d  = eff_prec(i_precision);
        pend_load_d  = i_load;
      end
    end else begin
      pend_valid_d = pend_valid_d;
    end

    ready_d = ~pend_valid_d;
    busy_d  = act_valid_d | pend_valid_d;
    first_d = act_valid_d & (cnt_d == PZERO);
    last_d  = act_valid_d & (cnt_d == (act_prec_d - PONE));
  end

  // State and registered status flags; reset discards any brick in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      act_valid_q  <= 1'b0;
      act_data_q   <= {DW{1'b0}};
      act_prec_q   <= PZERO;
      act_load_q   <= {Tw{1'b0}};
      cnt_q        <= PZERO;
      pend_valid_q <= 1'b0;
      pend_data_q  <= {DW{1'b0}};
      pend_prec_q  <= PZERO;
      pend_load_q  <= {Tw{1'b0}};
      ready_q      <= 1'b0;
      first_q      <= 1'b0;
      last_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      act_valid_q  <= act_valid_d;
      act_data_q   <= act_data_d;
      act_prec_q   <= act_prec_d;
      act_load_q   <= act_load_d;
      cnt_q        <= cnt_d;
      pend_valid_q <= pend_valid_d;
      pend_data_q  <= pend_data_d;
      pend_prec_q  <= pend_prec_d;
      pend_load_q  <= pend_load_d;
      ready_q      <= ready_d;
      first_q      <= first_d;
      last_q       <= last_d;
      busy_q       <= busy_d;
    end
  end

  // The current bit of every neuron is the LSB of its shift lane.
  always_comb begin
    serial_s = {LANES{1'b0}};
    for (int l = 0; l < LANES; l++) begin
      serial_s[l] = act_data_q[l*N];
    end
  end

  assign o_ready       = ready_q;
  assign o_valid       = act_valid_q;
  assign o_serial      = serial_s;
  assign o_first_cycle = first_q;
  assign o_last_cycle  = last_q;
  assign o_precision   = act_prec_q;
  assign o_load        = act_load_q;
  assign o_busy        = busy_q;

endmodule

// File: doc/stripes_serial_dispatcher.md
Name: stripes_serial_dispatcher

Overview:
- Feeds the Stripes node from the NBin side. Each accepted brick holds Tw windows x Tn neurons of N-bit values.
- Converts the brick into a bit-serial stream, LSB first, one bit per neuron per cycle, for i_precision cycles.
- Drives the node's first-cycle, precision and load controls alongside the stream.
- Two-entry buffer (active + pending) so consecutive bricks stream back-to-back with no bubble.

Parameters:
N, 16, neuron value width in bits
Tn, 16, neurons per window
Tw, 16, windows per brick
PREC_W, 5, width of the precision field

Ports:
clk  in  1  main clock
reset  in  1  asynchronous, active-low reset
i_valid  in  1  upstream brick valid
o_ready  out  1  dispatcher can accept a brick
i_neurons  in  N*Tn*Tw  brick; window w, neuron n at bits [(w*Tn+n)*N +: N]
i_precision  in  PREC_W  bits to serialise; 0 or >N means N
i_load  in  Tw  per-window load mask, carried with the brick
o_valid  out  1  serial beat valid
i_ready  in  1  node accepts the beat
o_serial  out  Tn*Tw  bit k of each neuron; window w, neuron n at bit w*Tn+n
o_first_cycle  out  1  beat is bit 0 of a brick
o_last_cycle  out  1  beat is bit p-1 of a brick
o_precision  out  PREC_W  effective precision p of the active brick
o_load  out  Tw  load mask of the active brick
o_busy  out  1  active or pending slot occupied

Behaviour:
- Reset (reset=0, asynchronous): both slots empty; bit counter 0; all outputs 0; o_ready=1 after release.
- Effective precision: p = N if i_precision==0 or i_precision>N, else i_precision. p is computed at acceptance and stored with the brick.
- Input handshake: transfer occurs when i_valid & o_ready at a clock edge.
- o_ready = !pending_valid. It is registered from state and never depends combinationally on i_valid.
- Accept with the active slot empty, or with the active slot completing on the same edge and pending empty: the brick goes directly to active, counter = 0.
- Accept with the active slot busy and not completing on that edge: the brick goes to pending.
- Active slot: per-neuron N-bit shift register. o_serial = LSB of every shift register.
- o_valid = active_valid.
- Output handshake: a beat fires when o_valid & i_ready.
  - On a fire, all registers shift right by 1 and the counter increments.
  - Without a fire, everything holds: o_serial, flags and counter stay stable under stall.
- o_first_cycle = active_valid & (counter==0).
- o_last_cycle = active_valid & (counter==p-1).
- o_precision and o_load are constant for the whole brick and 0 when idle.
- Completion: a fire with o_last_cycle set.
  - Pending occupied: pending moves to active on the same edge, counter = 0. The next cycle is bit 0 of the new brick with no gap.
  - Pending empty but a new brick accepted on that edge: that brick goes straight to active.
  - Neither: active_valid clears.
- p=1: every beat is both first and last.
- Throughput: one beat per cycle while i_ready=1. A brick of precision p takes exactly p fires.
- Latency: a brick accepted into an empty dispatcher appears as bit 0 on the cycle after acceptance.
- Bits above p-1 are never emitted.
- o_busy = active_valid | pending_valid.
- Reset asserted mid-brick: the brick is discarded immediately; no partial completion.

Test Plan:
- Reset, then accept one brick with all neurons = 16'h00A5, p=8, i_ready=1 -> 8 beats, o_serial all-ones/all-zeros per bits 1,0,1,0,0,1,0,1; o_first_cycle on beat 0, o_last_cycle on beat 7; then o_valid=0.
- i_precision=0 with neuron[0]=16'h8001, others 0 -> 16 beats; o_serial[0]=1 on beats 0 and 15 only; o_precision=16. Repeat with i_precision=20 -> identical result.
- Three bricks offered back-to-back, p=4, continuous i_i_valid -> 12 consecutive valid beats, no gaps; o_ready low while pending full; o_load switches exactly at each o_first_cycle.
- p=6, i_ready toggled 1,0,0,1,... -> exactly 6 fires; o_serial and counter unchanged on stalled cycles; o_last_cycle only on the 6th fire.
- p=1, four bricks streamed -> every beat has o_first_cycle=o_last_cycle=1; one beat per brick.
- Assert reset on beat 3 of a p=10 brick with pending full -> all outputs 0 asynchronously; o_busy=0; o_ready=1 after release; a new brick then starts from bit 0.
